// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default geometry for the SPI register slave.
package spi_pkg;

   localparam int unsigned SPI_ADDR_W      = 8;
   localparam int unsigned SPI_DATA_W      = 32;
   localparam int unsigned SPI_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchroniser for an asynchronous level, with rise/fall
// pulses taken against one further registered copy of the synchronised value.
module spi_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_rise_c,
   output logic o_fall_c
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   // Synchroniser chain plus the delayed copy used for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= STAGES'({r_sync, i_d});
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_rise_c =  r_sync[STAGES-1] & ~r_prev;
   assign o_fall_c = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_slave_rw.sv
// spi_slave_rw: mode-0 SPI slave; each frame is ADDR_W command bits (W flag +
// address) followed by DATA_W data bits, bridged onto read/write strobes.
// Write frames are only honoured when SPI_SLAVE_RW_WRITE_EN is defined;
// otherwise every frame is a read and the write port is tied to zero.
module spi_slave_rw
   import spi_pkg::*;
#(
   parameter int unsigned ADDR_W      = SPI_ADDR_W,
   parameter int unsigned DATA_W      = SPI_DATA_W,
   parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              SPI_CLK,
   input  logic              SPI_CS,
   input  logic              SPI_MOSI,
   output logic              SPI_MISO,
   output logic [ADDR_W-2:0] Data_Addr,
   input  logic [DATA_W-1:0] Data_Read,
   output logic              Data_RE,
   output logic [DATA_W-1:0] Data_Write,
   output logic              Data_WE,
   output logic              Frame_Err
);

   localparam int unsigned SYNC_N     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned FRAME_BITS = ADDR_W + DATA_W;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

   spi_state_e        r_state;
   spi_state_e        w_next;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [ADDR_W-2:0] r_cmd;
   logic [DATA_W-2:0] r_tx;
   logic              r_first;
   logic              r_miso;
   logic [ADDR_W-2:0] r_addr;
   logic              r_re;
   logic              r_ferr;
   logic              w_sclk_rise;
   logic              w_sclk_fall;
   logic              w_cs_rise;
   logic              w_cs_fall;
   logic              w_last_cmd;
   logic              w_last_data;
   logic              w_is_write;

   spi_sync #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sync_sclk (
      .i_clk    (Clk),
      .i_rst_n  (Reset_n),
      .i_d      (SPI_CLK),
      .o_rise_c (w_sclk_rise),
      .o_fall_c (w_sclk_fall)
   );

   spi_sync #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_sync_cs (
      .i_clk    (Clk),
      .i_rst_n  (Reset_n),
      .i_d      (SPI_CS),
      .o_rise_c (w_cs_rise),
      .o_fall_c (w_cs_fall)
   );

   // Frame state register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Next-state decode; CS deassertion returns to IDLE from any state.
   always_comb begin
      w_next      = r_state;
      w_last_cmd  = w_sclk_rise && (r_bit_cnt == CNT_W'(ADDR_W - 1));
      w_last_data = w_sclk_rise && (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
      unique case (r_state)
         ST_IDLE: if (w_cs_fall)   w_next = ST_CMD;
         ST_CMD:  if (w_last_cmd)  w_next = ST_DATA;
         ST_DATA: if (w_last_data) w_next = ST_DONE;
         ST_DONE: w_next = ST_DONE;
         default: w_next = ST_IDLE;
      endcase
      if (w_cs_rise) w_next = ST_IDLE;
   end

   // Bit counting, command capture, address update and read-data shift-out.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_bit_cnt <= '0;
         r_cmd     <= '0;
         r_tx      <= '0;
         r_first   <= 1'b0;
         r_miso    <= 1'b0;
         r_addr    <= '0;
         r_re      <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_re   <= 1'b0;
         r_ferr <= 1'b0;
         if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_first <= 1'b0;
            if ((r_state == ST_CMD) || (r_state == ST_DATA)) r_ferr <= 1'b1;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (w_cs_fall) begin
                     r_bit_cnt <= '0;
                     r_cmd     <= '0;
                     r_tx      <= '0;
                     r_first   <= 1'b0;
                     r_miso    <= 1'b0;
                  end
               end
               ST_CMD: begin
                  if (w_sclk_rise) begin
                     if (r_bit_cnt != CNT_W'(FRAME_BITS)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     // The W flag shifts out of the top, leaving only the address.
                     r_cmd <= (ADDR_W-1)'({r_cmd, SPI_MOSI});
                     if (w_last_cmd) r_first <= 1'b1;
                  end
               end
               ST_DATA: begin
                  if (w_sclk_rise) begin
                     if (r_bit_cnt != CNT_W'(FRAME_BITS)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     if (w_last_data) r_miso <= 1'b0;
                  end else if (w_sclk_fall) begin
                     if (r_first) begin
                        r_first <= 1'b0;
                        r_addr  <= r_cmd;
                        if (!w_is_write) begin
                           r_re   <= 1'b1;
                           r_miso <= Data_Read[DATA_W-1];
                           r_tx   <= Data_Read[DATA_W-2:0];
                        end
                     end else if (!w_is_write) begin
                        r_miso <= r_tx[DATA_W-2];
                        r_tx   <= (DATA_W-1)'({r_tx, 1'b0});
                     end
                  end
               end
               ST_DONE: r_miso <= 1'b0;
               default: r_miso <= 1'b0;
            endcase
         end
      end
   end

`ifdef SPI_SLAVE_RW_WRITE_EN
   logic              r_wr;
   logic [DATA_W-2:0] r_rx;
   logic [DATA_W-1:0] r_data_write;
   logic              r_we;

   // Write path: latch the W flag, collect data bits, strobe on DONE entry.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_wr         <= 1'b0;
         r_rx         <= '0;
         r_data_write <= '0;
         r_we         <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if ((r_state == ST_IDLE) && w_cs_fall) begin
            r_wr <= 1'b0;
            r_rx <= '0;
         end else if (w_sclk_rise && !w_cs_rise) begin
            if ((r_state == ST_CMD) && (r_bit_cnt == '0)) r_wr <= SPI_MOSI;
            if (r_state == ST_DATA) begin
               r_rx <= (DATA_W-1)'({r_rx, SPI_MOSI});
               if (w_last_data && r_wr) begin
                  r_data_write <= {r_rx, SPI_MOSI};
                  r_we         <= 1'b1;
               end
            end
         end
      end
   end

   assign w_is_write = r_wr;
   assign Data_Write = r_data_write;
   assign Data_WE    = r_we;
`else
   assign w_is_write = 1'b0;
   assign Data_Write = '0;
   assign Data_WE    = 1'b0;
`endif

   assign SPI_MISO  = r_miso;
   assign Data_Addr = r_addr;
   assign Data_RE   = r_re;
   assign Frame_Err = r_ferr;

endmodule

// File: tb/tb_spi_slave_rw.sv
// tb_spi_slave_rw: directed mode-0 master frames against spi_slave_rw.
// Expectations follow SPI_SLAVE_RW_WRITE_EN when the bench is built with it.
module tb_spi_slave_rw;
   import spi_pkg::*;

   localparam int HALF = 80;
   localparam int GAP  = 40;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        SPI_CLK = 1'b0;
   logic        SPI_CS = 1'b1;
   logic        SPI_MOSI = 1'b0;
   logic        SPI_MISO;
   logic [6:0]  Data_Addr;
   logic [31:0] Data_Read = 32'h0;
   logic        Data_RE;
   logic [31:0] Data_Write;
   logic        Data_WE;
   logic        Frame_Err;

   int n_cmp  = 0;
   int n_fail = 0;
   int re_cnt = 0;
   int we_cnt = 0;
   int fe_cnt = 0;

   spi_slave_rw #(.ADDR_W(8), .DATA_W(32), .SYNC_STAGES(2)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .SPI_CLK    (SPI_CLK),
      .SPI_CS     (SPI_CS),
      .SPI_MOSI   (SPI_MOSI),
      .SPI_MISO   (SPI_MISO),
      .Data_Addr  (Data_Addr),
      .Data_Read  (Data_Read),
      .Data_RE    (Data_RE),
      .Data_Write (Data_Write),
      .Data_WE    (Data_WE),
      .Frame_Err  (Frame_Err)
   );

   always #5 Clk = ~Clk;

   // Pulse counters sampled on the falling Clk edge.
   always @(negedge Clk) begin
      if (Data_RE === 1'b1)   re_cnt++;
      if (Data_WE === 1'b1)   we_cnt++;
      if (Frame_Err === 1'b1) fe_cnt++;
   end

   // One master frame: nbits bits of {cmd, wdata}; MISO sampled at each SCLK rise.
   task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] wdata, input int nbits,
                            input bit rst_at_end, output logic [31:0] rdata, output int cmd_ones);
      logic [39:0] frame;
      frame    = {cmd, wdata};
      rdata    = '0;
      cmd_ones = 0;
      @(negedge Clk);
      SPI_CS = 1'b0;
      #(HALF);
      for (int i = 0; i < nbits; i++) begin
         SPI_MOSI = frame[39-i];
         #(HALF);
         SPI_CLK = 1'b1;
         if (i < 8) begin
            if (SPI_MISO !== 1'b0) cmd_ones++;
         end else begin
            rdata[39-i] = SPI_MISO;
         end
         #(HALF);
         SPI_CLK = 1'b0;
      end
      #(HALF);
      if (rst_at_end) begin
         Reset_n = 1'b0;
         #20;
      end
      SPI_CS   = 1'b1;
      SPI_MOSI = 1'b0;
      #(GAP);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      #37;
      n_cmp++; if (SPI_MISO !== 1'b0)    begin n_fail++; $display("FAIL reset_miso: got %b want 0", SPI_MISO); end
      n_cmp++; if (Data_Addr !== 7'h00)  begin n_fail++; $display("FAIL reset_addr: got %h want 00", Data_Addr); end
      n_cmp++; if (Data_RE !== 1'b0)     begin n_fail++; $display("FAIL reset_re: got %b want 0", Data_RE); end
      n_cmp++; if (Data_WE !== 1'b0)     begin n_fail++; $display("FAIL reset_we: got %b want 0", Data_WE); end
      n_cmp++; if (Data_Write !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", Data_Write); end
      n_cmp++; if (Frame_Err !== 1'b0)   begin n_fail++; $display("FAIL reset_ferr: got %b want 0", Frame_Err); end
      n_cmp++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.r_state); end
      Reset_n = 1'b1;
      #50;
   endtask

   task automatic test_read();
      logic [31:0] rd; int ones; int re0, we0, fe0;
      re0 = re_cnt; we0 = we_cnt; fe0 = fe_cnt;
      Data_Read = 32'hDEADBEEF;
      spi_frame(8'h05, 32'h0, 40, 1'b0, rd, ones);
      n_cmp++; if (rd !== 32'hDEADBEEF)    begin n_fail++; $display("FAIL read_miso: got %h want deadbeef", rd); end
      n_cmp++; if (ones !== 0)             begin n_fail++; $display("FAIL read_cmd_miso: got %0d ones want 0", ones); end
      n_cmp++; if (Data_Addr !== 7'h05)    begin n_fail++; $display("FAIL read_addr: got %h want 05", Data_Addr); end
      n_cmp++; if (re_cnt - re0 !== 1)     begin n_fail++; $display("FAIL read_re_count: got %0d want 1", re_cnt - re0); end
      n_cmp++; if (we_cnt - we0 !== 0)     begin n_fail++; $display("FAIL read_we_count: got %0d want 0", we_cnt - we0); end
      n_cmp++; if (fe_cnt - fe0 !== 0)     begin n_fail++; $display("FAIL read_ferr_count: got %0d want 0", fe_cnt - fe0); end
      n_cmp++; if (SPI_MISO !== 1'b0)      begin n_fail++; $display("FAIL read_miso_idle: got %b want 0", SPI_MISO); end
   endtask

   task automatic test_write();
      logic [31:0] rd; int ones; int re0, we0;
      re0 = re_cnt; we0 = we_cnt;
      Data_Read = 32'hCAFEF00D;
      spi_frame(8'h85, 32'h12345678, 40, 1'b0, rd, ones);
      n_cmp++; if (Data_Addr !== 7'h05) begin n_fail++; $display("FAIL write_addr: got %h want 05", Data_Addr); end
      n_cmp++; if (ones !== 0)          begin n_fail++; $display("FAIL write_cmd_miso: got %0d ones want 0", ones); end
`ifdef SPI_SLAVE_RW_WRITE_EN
      n_cmp++; if (rd !== 32'h0)                 begin n_fail++; $display("FAIL write_miso: got %h want 0", rd); end
      n_cmp++; if (we_cnt - we0 !== 1)           begin n_fail++; $display("FAIL write_we_count: got %0d want 1", we_cnt - we0); end
      n_cmp++; if (Data_Write !== 32'h12345678)  begin n_fail++; $display("FAIL write_data: got %h want 12345678", Data_Write); end
      n_cmp++; if (re_cnt - re0 !== 0)           begin n_fail++; $display("FAIL write_re_count: got %0d want 0", re_cnt - re0); end
`else
      n_cmp++; if (rd !== 32'hCAFEF00D)          begin n_fail++; $display("FAIL nowr_miso: got %h want cafef00d", rd); end
      n_cmp++; if (we_cnt - we0 !== 0)           begin n_fail++; $display("FAIL nowr_we_count: got %0d want 0", we_cnt - we0); end
      n_cmp++; if (Data_Write !== 32'h0)         begin n_fail++; $display("FAIL nowr_data: got %h want 0", Data_Write); end
      n_cmp++; if (re_cnt - re0 !== 1)           begin n_fail++; $display("FAIL nowr_re_count: got %0d want 1", re_cnt - re0); end
`endif
   endtask

   task automatic test_abort();
      logic [31:0] rd; int ones; int we0, fe0;
      we0 = we_cnt; fe0 = fe_cnt;
      spi_frame(8'h85, 32'h12345678, 20, 1'b0, rd, ones);
      #100;
      n_cmp++; if (fe_cnt - fe0 !== 1)      begin n_fail++; $display("FAIL abort_ferr_count: got %0d want 1", fe_cnt - fe0); end
      n_cmp++; if (we_cnt - we0 !== 0)      begin n_fail++; $display("FAIL abort_we_count: got %0d want 0", we_cnt - we0); end
      n_cmp++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d want IDLE", dut.r_state); end
      n_cmp++; if (SPI_MISO !== 1'b0)       begin n_fail++; $display("FAIL abort_miso: got %b want 0", SPI_MISO); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; int ones; int re0, we0, fe0;
      re0 = re_cnt; we0 = we_cnt; fe0 = fe_cnt;
      Data_Read = 32'h13579BDF;
      spi_frame(8'h01, 32'h0, 40, 1'b0, rd, ones);
      n_cmp++; if (rd !== 32'h13579BDF)  begin n_fail++; $display("FAIL b2b_rd_miso: got %h want 13579bdf", rd); end
      n_cmp++; if (Data_Addr !== 7'h01)  begin n_fail++; $display("FAIL b2b_rd_addr: got %h want 01", Data_Addr); end
      n_cmp++; if (re_cnt - re0 !== 1)   begin n_fail++; $display("FAIL b2b_rd_re: got %0d want 1", re_cnt - re0); end
      Data_Read = 32'h2468ACE0;
      spi_frame(8'h82, 32'hA5A5A5A5, 40, 1'b0, rd, ones);
      #60;
      n_cmp++; if (Data_Addr !== 7'h02)  begin n_fail++; $display("FAIL b2b_wr_addr: got %h want 02", Data_Addr); end
      n_cmp++; if (fe_cnt - fe0 !== 0)   begin n_fail++; $display("FAIL b2b_ferr: got %0d want 0", fe_cnt - fe0); end
`ifdef SPI_SLAVE_RW_WRITE_EN
      n_cmp++; if (rd !== 32'h0)                begin n_fail++; $display("FAIL b2b_wr_miso: got %h want 0", rd); end
      n_cmp++; if (Data_Write !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_wr_data: got %h want a5a5a5a5", Data_Write); end
      n_cmp++; if (we_cnt - we0 !== 1)          begin n_fail++; $display("FAIL b2b_we: got %0d want 1", we_cnt - we0); end
      n_cmp++; if (re_cnt - re0 !== 1)          begin n_fail++; $display("FAIL b2b_re_total: got %0d want 1", re_cnt - re0); end
`else
      n_cmp++; if (rd !== 32'h2468ACE0)         begin n_fail++; $display("FAIL b2b_nowr_miso: got %h want 2468ace0", rd); end
      n_cmp++; if (we_cnt - we0 !== 0)          begin n_fail++; $display("FAIL b2b_nowr_we: got %0d want 0", we_cnt - we0); end
      n_cmp++; if (re_cnt - re0 !== 2)          begin n_fail++; $display("FAIL b2b_re_total: got %0d want 2", re_cnt - re0); end
`endif
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] rd; int ones; int re0, we0, fe0;
      we0 = we_cnt; fe0 = fe_cnt;
      spi_frame(8'h85, 32'hFFFF0000, 30, 1'b1, rd, ones);
      n_cmp++; if (SPI_MISO !== 1'b0)       begin n_fail++; $display("FAIL rmid_miso: got %b want 0", SPI_MISO); end
      n_cmp++; if (Data_Addr !== 7'h00)     begin n_fail++; $display("FAIL rmid_addr: got %h want 00", Data_Addr); end
      n_cmp++; if (Data_Write !== 32'h0)    begin n_fail++; $display("FAIL rmid_wdata: got %h want 0", Data_Write); end
      n_cmp++; if (Data_RE !== 1'b0)        begin n_fail++; $display("FAIL rmid_re: got %b want 0", Data_RE); end
      n_cmp++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d want IDLE", dut.r_state); end
      Reset_n = 1'b1;
      #100;
      n_cmp++; if (we_cnt - we0 !== 0)      begin n_fail++; $display("FAIL rmid_we_count: got %0d want 0", we_cnt - we0); end
      n_cmp++; if (fe_cnt - fe0 !== 0)      begin n_fail++; $display("FAIL rmid_ferr_count: got %0d want 0", fe_cnt - fe0); end
      re0 = re_cnt;
      Data_Read = 32'h600DCAFE;
      spi_frame(8'h03, 32'h0, 40, 1'b0, rd, ones);
      n_cmp++; if (rd !== 32'h600DCAFE)     begin n_fail++; $display("FAIL rmid_read_miso: got %h want 600dcafe", rd); end
      n_cmp++; if (Data_Addr !== 7'h03)     begin n_fail++; $display("FAIL rmid_read_addr: got %h want 03", Data_Addr); end
      n_cmp++; if (re_cnt - re0 !== 1)      begin n_fail++; $display("FAIL rmid_read_re: got %0d want 1", re_cnt - re0); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_abort();
      test_back_to_back();
      test_reset_mid_frame();
      #100;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_rw.md
SPI_SLAVE_RW -- requirements
Module: spi_slave_rw

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: command-phase length in bits (1 R/W flag + ADDR_W-1 address bits).
REQ-002 SHALL have parameter DATA_W, default 32: data-phase length in bits.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for SPI_CLK and SPI_CS, minimum 2.
REQ-004 Clk  in  1  system clock; one clock, all logic rising-edge.
REQ-005 Reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SPI_CLK  in  1  SPI clock from master (mode 0), asynchronous to Clk.
REQ-007 SPI_CS  in  1  chip select, active-low, asynchronous.
REQ-008 SPI_MOSI  in  1  serial data from master, MSB first.
REQ-009 SPI_MISO  out  1  serial data to master, MSB first.
REQ-010 Data_Addr  out  ADDR_W-1  decoded register address.
REQ-011 Data_Read  in  DATA_W  read data for Data_Addr, sampled on Data_RE.
REQ-012 Data_RE  out  1  one-Clk read strobe.
REQ-013 Data_Write  out  DATA_W  write data, valid with Data_WE.
REQ-014 Data_WE  out  1  one-Clk write strobe.
REQ-015 Frame_Err  out  1  one-Clk pulse on aborted frame.

Function
REQ-016 Frame = ADDR_W command bits then DATA_W data bits; command bit ADDR_W-1 is W (1=write), bits ADDR_W-2:0 are the address.
REQ-017 SPI_CLK and SPI_CS SHALL pass through SYNC_STAGES flops; edges are detected against a further registered copy; MOSI sampled on the Clk cycle a rising SPI_CLK edge is detected.
REQ-018 FSM states IDLE, CMD, DATA, DONE; IDLE->CMD on CS falling (bit counter, shift reg, MISO cleared); CMD->DATA after ADDR_W-th rising edge; DATA->DONE after DATA_W-th rising edge; DONE->IDLE on CS rising; any state ->IDLE on CS rising.
REQ-019 On the first falling SPI_CLK edge in DATA: Data_Addr updated, and for a read Data_RE pulses and SPI_MISO = Data_Read[DATA_W-1] in that same Clk cycle; remaining bits shifted out on subsequent falling edges.
REQ-020 SPI_MISO SHALL be 0 during CMD, during write frames, and in DONE.
REQ-021 For a write, on DONE entry Data_Write = received data and Data_WE pulses exactly one Clk; Data_Write holds until next write.
REQ-022 CS rising in CMD or DATA SHALL pulse Frame_Err one Clk; no Data_WE for that frame.
REQ-023 SPI_CLK edges in DONE or IDLE SHALL be ignored; bit counter saturates, never wraps.
REQ-024 Correct operation SHALL be guaranteed for SPI_CLK <= Clk/8; CS high time >= 4 Clk.

Reset
REQ-025 Reset_n low SHALL asynchronously force IDLE, SPI_MISO=0, Data_Addr=0, Data_Write=0, Data_RE=0, Data_WE=0, Frame_Err=0, CS sync chain=1, SCLK sync chain=0.
REQ-026 Reset mid-frame SHALL abandon the frame without Data_WE or Frame_Err; the next CS falling edge starts a fresh frame.

Configuration
REQ-027 Macro SPI_SLAVE_RW_WRITE_EN defined: write frames per REQ-021.
REQ-028 Undefined: W bit ignored, every frame is a read, Data_WE and Data_Write tied to 0.

Structure
REQ-029 Package spi_pkg SHALL hold the state enum typedef and default ADDR_W/DATA_W/SYNC_STAGES constants.
REQ-030 Sub-module spi_sync (SYNC_STAGES synchroniser plus rise/fall pulse outputs, reset value parameter) SHALL be instantiated for SPI_CLK and SPI_CS.

Verification (ADDR_W=8, DATA_W=32)
REQ-031 Read: cmd 0x05, Data_Read=0xDEADBEEF -> one Data_RE, Data_Addr=0x05, MISO data bits = 0xDEADBEEF, no Data_WE.
REQ-032 Write (macro on): cmd 0x85, data 0x12345678 -> Data_Addr=0x05, single Data_WE with Data_Write=0x12345678, MISO all 0.
REQ-033 Abort: CS high after 20 bits of write frame -> one Frame_Err pulse, no Data_WE, FSM IDLE.
REQ-034 Back-to-back: read 0x01 then write 0x82/0xA5A5A5A5 with 4-Clk CS gap -> both transactions correct, no Frame_Err.
REQ-035 Reset_n low at bit 30 of write frame -> all outputs 0, no Data_WE; next read of 0x03 correct.
REQ-036 Macro off: cmd 0x85 -> treated as read of 0x05, Data_RE pulses, Data_WE stays 0.
